// File: rtl/lio_i8080_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : lio_i8080_pkg                                                |
// | Description : Shared types, command codes and helpers for the 8080-style   |
// |               display bus master.                                          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package lio_i8080_pkg;

  // Byte lane width carried by the request record.
  localparam int I8080_DW = 8;

  // Common display-controller command codes (not interpreted by the master).
  localparam logic [7:0] I8080_CMD_MEM_WRITE = 8'h1C;
  localparam logic [7:0] I8080_CMD_MEM_READ  = 8'h1D;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SETUP     = 2'd1,
    STROBE_LO = 2'd2,
    STROBE_HI = 2'd3
  } i8080_state_t;

  typedef struct packed {
    logic                dc;     // 0 = command, 1 = data
    logic                rd;     // 0 = write,   1 = read
    logic [I8080_DW-1:0] wdata;
  } i8080_req_t;

  // A phase length must fit the counter and last at least one cycle.
  function automatic logic phase_len_ok(input int len, input int cnt_w);
    return (len >= 1) && (len <= ((1 << cnt_w) - 1));
  endfunction

endpackage
`default_nettype wire

// File: rtl/lio_i8080_phase_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : lio_i8080_phase_timer                                        |
// | Description : Loadable down-counter timing one bus phase. Loading N makes  |
// |               o_last rise on the N-th cycle of the phase.                  |
// | Ports       : clk, rst       - clock, synchronous active-high reset        |
// |               i_load         - start a new phase                           |
// |               i_load_val     - phase length in cycles (>= 1)               |
// |               o_last         - current cycle is the last of the phase      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module lio_i8080_phase_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_last
);

  localparam logic [CNT_W-1:0] c_one = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt;

  // The counter holds "cycles remaining after this one", so a phase of
  // length N is loaded as N-1 and is finished when the count reaches zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val - c_one;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - c_one;
    end
  end

  assign o_last = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/lio_i8080_bus_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : lio_i8080_bus_master                                         |
// | Description : Synchronous master for an 8080-style LCD bus. Converts a     |
// |               valid/ready stream of command/data write/read requests into  |
// |               timed ce/dc/wr/rd strobes and returns read bytes on a        |
// |               one-cycle response pulse. The tri-state pad is built by the  |
// |               integrator from o_d_o / o_d_oe / i_d_i.                      |
// | Ports       : clk, rst             - clock, synchronous active-high reset  |
// |               i_req_valid/o_req_ready, i_req_dc, i_req_rd, i_req_wdata     |
// |                                    - request stream                        |
// |               o_rsp_valid, o_rsp_rdata - read response                     |
// |               o_busy               - transfer in progress                  |
// |               o_ce, o_dc, o_wr, o_rd - bus controls (ce/wr/rd active-low)  |
// |               o_d_o, o_d_oe, i_d_i - bus data drive / enable / sample      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module lio_i8080_bus_master
  import lio_i8080_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int T_SU       = 1,
  parameter int T_WRL      = 2,
  parameter int T_WRH      = 2,
  parameter int T_RDL      = 4,
  parameter int T_RDH      = 2,
  parameter int CNT_W      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_dc,
  input  logic                  i_req_rd,
  input  logic [DATA_WIDTH-1:0] i_req_wdata,
  output logic                  o_rsp_valid,
  output logic [DATA_WIDTH-1:0] o_rsp_rdata,
  output logic                  o_busy,
  output logic                  o_ce,
  output logic                  o_dc,
  output logic                  o_wr,
  output logic                  o_rd,
  output logic [DATA_WIDTH-1:0] o_d_o,
  output logic                  o_d_oe,
  input  logic [DATA_WIDTH-1:0] i_d_i
);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ---------------------------------------------------------------------------
  if (DATA_WIDTH != I8080_DW) begin : g_bad_data_width
    $error("DATA_WIDTH must match the request record byte width");
  end
  if (!phase_len_ok(T_SU, CNT_W)) begin : g_bad_t_su
    $error("T_SU out of range for CNT_W");
  end
  if (!phase_len_ok(T_WRL, CNT_W)) begin : g_bad_t_wrl
    $error("T_WRL out of range for CNT_W");
  end
  if (!phase_len_ok(T_WRH, CNT_W)) begin : g_bad_t_wrh
    $error("T_WRH out of range for CNT_W");
  end
  if (!phase_len_ok(T_RDL, CNT_W)) begin : g_bad_t_rdl
    $error("T_RDL out of range for CNT_W");
  end
  if (!phase_len_ok(T_RDH, CNT_W)) begin : g_bad_t_rdh
    $error("T_RDH out of range for CNT_W");
  end

  localparam logic [CNT_W-1:0] c_su  = CNT_W'(T_SU);
  localparam logic [CNT_W-1:0] c_wrl = CNT_W'(T_WRL);
  localparam logic [CNT_W-1:0] c_wrh = CNT_W'(T_WRH);
  localparam logic [CNT_W-1:0] c_rdl = CNT_W'(T_RDL);
  localparam logic [CNT_W-1:0] c_rdh = CNT_W'(T_RDH);

  i8080_state_t     r_state;
  i8080_state_t     w_next_state;
  i8080_req_t       r_req;
  logic             r_out_en;
  logic             r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;

  logic             w_last;
  logic             w_load;
  logic [CNT_W-1:0] w_load_val;
  logic             w_req_ready;
  logic             w_accept;
  logic             w_rd_sample;

  assign w_accept = i_req_valid && w_req_ready;

  // Read data is captured on the final low cycle of rd, so the response
  // pulse lines up with the first high cycle.
  assign w_rd_sample = (r_state == STROBE_LO) && w_last && r_req.rd;

  // ---------------------------------------------------------------------------
  // Shared phase timer: reloaded on every phase transition
  // ---------------------------------------------------------------------------
  lio_i8080_phase_timer #(
    .CNT_W (CNT_W)
  ) u_phase_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_last     (w_last)
  );

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state and phase-timer load
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_load_val   = c_su;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_next_state = SETUP;
          w_load       = 1'b1;
          w_load_val   = c_su;
        end
      end
      SETUP: begin
        if (w_last) begin
          w_next_state = STROBE_LO;
          w_load       = 1'b1;
          w_load_val   = r_req.rd ? c_rdl : c_wrl;
        end
      end
      STROBE_LO: begin
        if (w_last) begin
          w_next_state = STROBE_HI;
          w_load       = 1'b1;
          w_load_val   = r_req.rd ? c_rdh : c_wrh;
        end
      end
      STROBE_HI: begin
        if (w_last) begin
          // A request taken here chains straight into SETUP so ce stays low
          // across the burst.
          if (w_accept) begin
            w_next_state = SETUP;
            w_load       = 1'b1;
            w_load_val   = c_su;
          end else begin
            w_next_state = IDLE;
          end
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    o_busy      = (r_state != IDLE);
    o_ce        = (r_state == IDLE);
    o_dc        = r_req.dc;
    o_d_o       = r_req.wdata;
    // Writes drive the bus from SETUP through the last high cycle (hold);
    // reads never drive, which also covers the rd-high turnaround.
    o_d_oe      = (r_state != IDLE) && !r_req.rd;
    o_wr        = !((r_state == STROBE_LO) && !r_req.rd);
    o_rd        = !((r_state == STROBE_LO) &&  r_req.rd);
    w_req_ready = r_out_en &&
                  ((r_state == IDLE) || ((r_state == STROBE_HI) && w_last));
  end

  assign o_req_ready = w_req_ready;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_rdata = r_rsp_rdata;

  // ---------------------------------------------------------------------------
  // Request latch, ready enable and read response
  // ---------------------------------------------------------------------------
  // r_out_en keeps req_ready low while reset is held and for the reset edge
  // itself, releasing it one cycle after rst is sampled low.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_en    <= 1'b0;
      r_req.dc    <= 1'b1;
      r_req.rd    <= 1'b0;
      r_req.wdata <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_out_en    <= 1'b1;
      r_rsp_valid <= w_rd_sample;
      if (w_accept) begin
        r_req.dc    <= i_req_dc;
        r_req.rd    <= i_req_rd;
        r_req.wdata <= i_req_wdata;
      end
      if (w_rd_sample) begin
        r_rsp_rdata <= i_d_i;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lio_i8080_bus_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_lio_i8080_bus_master                                      |
// | Description : Directed self-checking bench for lio_i8080_bus_master with a |
// |               behavioural display memory on a resolved data bus.           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_lio_i8080_bus_master;
  import lio_i8080_pkg::*;

  localparam int DW    = 8;
  localparam int T_SU  = 1;
  localparam int T_WRL = 2;
  localparam int T_WRH = 2;
  localparam int T_RDL = 4;
  localparam int T_RDH = 2;
  localparam int CNT_W = 4;
  localparam logic [7:0] c_dummy = 8'hEE;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_dc = 1'b0;
  logic          req_rd = 1'b0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          busy;
  logic          ce;
  logic          dc;
  logic          wr_n;
  logic          rd_n;
  logic [DW-1:0] d_o;
  logic          d_oe;
  logic [DW-1:0] d_i;

  always #5 clk = ~clk;

  lio_i8080_bus_master #(
    .DATA_WIDTH (DW),
    .T_SU       (T_SU),
    .T_WRL      (T_WRL),
    .T_WRH      (T_WRH),
    .T_RDL      (T_RDL),
    .T_RDH      (T_RDH),
    .CNT_W      (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_dc    (req_dc),
    .i_req_rd    (req_rd),
    .i_req_wdata (req_wdata),
    .o_rsp_valid (rsp_valid),
    .o_rsp_rdata (rsp_rdata),
    .o_busy      (busy),
    .o_ce        (ce),
    .o_dc        (dc),
    .o_wr        (wr_n),
    .o_rd        (rd_n),
    .o_d_o       (d_o),
    .o_d_oe      (d_oe),
    .i_d_i       (d_i)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_rsp    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Display memory model and bus resolution
  // ---------------------------------------------------------------------------
  logic [7:0] mem [0:15];
  int         wptr = 0;
  int         rptr = 0;
  logic [7:0] cmd = 8'h00;
  logic       rd_first = 1'b0;
  logic       mem_drv;
  logic [7:0] mem_q;

  assign mem_drv = !ce && !rd_n;
  always_comb mem_q = rd_first ? c_dummy : mem[rptr[3:0]];
  always_comb d_i = mem_drv ? mem_q : (d_oe ? d_o : 8'hzz);

  // ---------------------------------------------------------------------------
  // Bus protocol and response monitor (sampled on the falling edge)
  // ---------------------------------------------------------------------------
  typedef struct {int c; logic [7:0] d;} exp_t;
  exp_t rspq[$];

  logic       prev_wr = 1'b1;
  logic       prev_rd = 1'b1;
  logic       prev_dc = 1'b1;
  logic [7:0] prev_do = 8'h00;
  int         wr_lo = 0;
  int         rd_lo = 0;
  int         hold_cnt = 0;

  always @(negedge clk) begin
    if (cyc > 0) begin
      chk("oe_while_rd_low", {31'd0, d_oe && !rd_n}, 32'd0);
      chk("wr_rd_overlap", {31'd0, !wr_n && !rd_n}, 32'd0);
      chk("ce_vs_busy", {31'd0, ce}, {31'd0, !busy});
      if (!wr_n || !rd_n) begin
        chk("dc_stable", {31'd0, dc}, {31'd0, prev_dc});
        chk("do_stable", {24'd0, d_o}, {24'd0, prev_do});
      end
      // wr pulse width, write hold, and slave latch on wr rising
      if (!wr_n) begin
        wr_lo++;
      end else if (!prev_wr) begin
        chk("wr_low_width", wr_lo, T_WRL);
        wr_lo = 0;
        hold_cnt = T_WRH;
        if (!dc) begin
          cmd = d_o;
          if (d_o == I8080_CMD_MEM_WRITE) wptr = 0;
          if (d_o == I8080_CMD_MEM_READ) begin
            rptr = 0;
            rd_first = 1'b1;
          end
        end else if (cmd == I8080_CMD_MEM_WRITE) begin
          mem[wptr[3:0]] = d_o;
          wptr++;
        end
      end
      if (hold_cnt > 0) begin
        chk("wr_hold_oe", {31'd0, d_oe}, 32'd1);
        hold_cnt--;
      end
      // rd pulse width (not meaningful when cut short by reset)
      if (!rd_n) begin
        rd_lo++;
      end else if (!prev_rd) begin
        if (!rst) chk("rd_low_width", rd_lo, T_RDL);
        rd_lo = 0;
        if (dc && cmd == I8080_CMD_MEM_READ) begin
          if (rd_first) rd_first = 1'b0;
          else rptr++;
        end
      end
      if (rsp_valid) begin
        n_rsp++;
        if (rspq.size() == 0) begin
          chk("rsp_unexpected", {31'd0, rsp_valid}, 32'd0);
        end else begin
          exp_t e;
          e = rspq.pop_front();
          // Latency counted with the accept cycle as cycle one.
          chk("rsp_latency", cyc - e.c + 1, 1 + T_SU + T_RDL);
          chk("rsp_data", {24'd0, rsp_rdata}, {24'd0, e.d});
        end
      end
    end
    prev_wr = wr_n;
    prev_rd = rd_n;
    prev_dc = dc;
    prev_do = d_o;
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic send(input logic dc_i, input logic rd_i, input logic [7:0] wd,
                      input logic [7:0] exp_rd, output int acc);
    exp_t e;
    req_valid = 1'b1;
    req_dc    = dc_i;
    req_rd    = rd_i;
    req_wdata = wd;
    acc       = -1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (req_ready) begin
        @(posedge clk);
        #1;
        acc = cyc;
        break;
      end
    end
    req_valid = 1'b0;
    if (acc < 0) begin
      chk("accept_timeout", {31'd0, req_ready}, 32'd1);
    end else if (rd_i) begin
      e.c = acc;
      e.d = exp_rd;
      rspq.push_back(e);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int a0, a1, a2, a3, a4;
    int n;

    // Reset held for three cycles
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ce", {31'd0, ce}, 32'd1);
    chk("rst_wr", {31'd0, wr_n}, 32'd1);
    chk("rst_rd", {31'd0, rd_n}, 32'd1);
    chk("rst_dc", {31'd0, dc}, 32'd1);
    chk("rst_d_oe", {31'd0, d_oe}, 32'd0);
    chk("rst_d_o", {24'd0, d_o}, 32'd0);
    chk("rst_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", {24'd0, rsp_rdata}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", {31'd0, req_ready}, 32'd1);

    // Write burst: cmd 0x1C then three data bytes back-to-back
    send(1'b0, 1'b0, I8080_CMD_MEM_WRITE, 8'h00, a0);
    send(1'b1, 1'b0, 8'hA5, 8'h00, a1);
    send(1'b1, 1'b0, 8'h5A, 8'h00, a2);
    send(1'b1, 1'b0, 8'h3C, 8'h00, a3);
    chk("wr_burst_period0", a1 - a0, T_SU + T_WRL + T_WRH);
    chk("wr_burst_period1", a2 - a1, T_SU + T_WRL + T_WRH);
    chk("wr_burst_period2", a3 - a2, T_SU + T_WRL + T_WRH);
    wait_idle();
    chk("mem0", {24'd0, mem[0]}, 32'hA5);
    chk("mem1", {24'd0, mem[1]}, 32'h5A);
    chk("mem2", {24'd0, mem[2]}, 32'h3C);

    // Read burst: cmd 0x1D then dummy + three bytes
    send(1'b0, 1'b0, I8080_CMD_MEM_READ, 8'h00, a0);
    send(1'b1, 1'b1, 8'h00, c_dummy, a1);
    send(1'b1, 1'b1, 8'h00, 8'hA5, a2);
    send(1'b1, 1'b1, 8'h00, 8'h5A, a3);
    send(1'b1, 1'b1, 8'h00, 8'h3C, a4);
    chk("rd_after_cmd_period", a1 - a0, T_SU + T_WRL + T_WRH);
    chk("rd_burst_period", a3 - a2, T_SU + T_RDL + T_RDH);
    wait_idle();
    repeat (2) @(negedge clk);
    chk("rd_burst_rsp_count", n_rsp, 4);
    chk("rd_burst_rsp_pending", rspq.size(), 0);

    // Idle gap mid-stream
    send(1'b0, 1'b0, I8080_CMD_MEM_WRITE, 8'h00, a0);
    send(1'b1, 1'b0, 8'h11, 8'h00, a1);
    wait_idle();
    for (int i = 0; i < 5; i++) begin
      chk("gap_ce_high", {31'd0, ce}, 32'd1);
      @(negedge clk);
    end
    send(1'b1, 1'b0, 8'h22, 8'h00, a2);
    @(negedge clk);
    chk("restart_setup_ce", {31'd0, ce}, 32'd0);
    chk("restart_setup_wr", {31'd0, wr_n}, 32'd1);
    chk("restart_setup_oe", {31'd0, d_oe}, 32'd1);
    repeat (T_SU) @(negedge clk);
    chk("restart_wr_low", {31'd0, wr_n}, 32'd0);
    wait_idle();
    chk("gap_mem0", {24'd0, mem[0]}, 32'h11);
    chk("gap_mem1", {24'd0, mem[1]}, 32'h22);

    // Reset during the low phase of a read
    send(1'b0, 1'b0, I8080_CMD_MEM_READ, 8'h00, a0);
    send(1'b1, 1'b1, 8'h00, c_dummy, a1);
    n = 0;
    while (rd_n && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("rd_low_seen", {31'd0, rd_n}, 32'd0);
    rst = 1'b1;
    rspq.delete();
    n = n_rsp;
    @(negedge clk);
    chk("midrst_rd", {31'd0, rd_n}, 32'd1);
    chk("midrst_ce", {31'd0, ce}, 32'd1);
    chk("midrst_oe", {31'd0, d_oe}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_rsp", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("midrst_no_rsp", n_rsp, n);

    // Recovery: write 0x1C/0x77 then read it back
    send(1'b0, 1'b0, I8080_CMD_MEM_WRITE, 8'h00, a0);
    send(1'b1, 1'b0, 8'h77, 8'h00, a1);
    wait_idle();
    chk("recover_mem0", {24'd0, mem[0]}, 32'h77);
    send(1'b0, 1'b0, I8080_CMD_MEM_READ, 8'h00, a0);
    send(1'b1, 1'b1, 8'h00, c_dummy, a1);
    send(1'b1, 1'b1, 8'h00, 8'h77, a2);
    wait_idle();
    repeat (2) @(negedge clk);
    chk("recover_rsp_count", n_rsp, 6);
    chk("recover_rsp_pending", rspq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, observed running required finished");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
